sweep_ctrl: RTL and testbench
=============================

SWEEP_CTRL -- requirements
Module: sweep_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 50, meaning clk cycles per sample period; even, >=4.
REQ-002 SHALL have port clk  input  1  system clock.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  one-cycle sweep request, accepted only in IDLE.
REQ-005 SHALL have port abort  input  1  stop sweep; highest priority after rst.
REQ-006 SHALL have port mode  input  1  0 = single sweep, 1 = continuous loop; sampled at accepted start.
REQ-007 SHALL have ports f_start, f_stop, f_step  input  20 each  sweep frequency words (Hz); sampled at accepted start.
REQ-008 SHALL have port dwell  input  16  fall ticks per frequency step; sampled at accepted start.
REQ-009 SHALL have port s_clk  output  1  sample clock to the address generator.
REQ-010 SHALL have port en  output  1  address generator enable.
REQ-011 SHALL have port f_set  output  20  frequency word to the address generator.
REQ-012 SHALL have ports busy, done, err  output  1 each  status; done and err are one-cycle pulses.

Function
REQ-013 SHALL run a free-running divider div_cnt 0..DIV-1 from reset, independent of state; s_clk = 1 when div_cnt < DIV/2.
REQ-014 SHALL define fall_tick as the cycle where div_cnt == DIV/2; all f_set, en and dwell changes occur only on fall_tick, so f_set is stable at every s_clk rising edge.
REQ-015 SHALL implement states IDLE, LOAD, RUN, DONE.
REQ-016 IDLE: start with valid config -> latch config, LOAD next cycle; busy = 1 from the following cycle.
REQ-017 Config invalid when f_step == 0, dwell == 0 or f_start > f_stop; then err pulses 1 cycle after start, state stays IDLE, f_set unchanged.
REQ-018 LOAD: on next fall_tick -> f_set = f_start, en = 1, dwell_cnt = 0, RUN.
REQ-019 RUN: on each fall_tick dwell_cnt increments; when dwell_cnt == dwell-1 it clears and the step decision is taken on that same fall_tick.
REQ-020 Step decision uses 21-bit sum f_set + f_step: <= f_stop -> f_set = sum; > f_stop and mode = 1 -> f_set = f_start; > f_stop and mode = 0 -> DONE.
REQ-021 Each frequency is therefore held exactly dwell*DIV clk cycles; f_stop is emitted only when reachable by whole steps.
REQ-022 DONE: en = 0 and done = 1 for one cycle, f_set holds last value, IDLE next cycle; busy = 0 in DONE.
REQ-023 abort in any state -> IDLE next cycle, en = 0, busy = 0, no done pulse, f_set holds; abort wins over simultaneous start or step.
REQ-024 start while busy SHALL be ignored; start and abort together in IDLE -> stay IDLE.
REQ-025 busy = 1 in LOAD and RUN only; en = 1 in RUN only.
REQ-026 Latched config SHALL not change during a sweep regardless of input activity.

Reset
REQ-027 rst low SHALL force immediately: state IDLE, div_cnt 0, dwell_cnt 0, s_clk 1, en 0, f_set 0, busy 0, done 0, err 0.
REQ-028 rst mid-sweep SHALL abandon the sweep without done; after release the block idles until a new start.

Verification (DIV = 8)
REQ-029 mode 0, f_start 100, f_stop 400, f_step 100, dwell 2 -> f_set 100,200,300,400, each held 16 clk, changes only at div_cnt == 4, then one done pulse, en 0, f_set 400.
REQ-030 mode 0, f_start 100, f_stop 350, f_step 100, dwell 1 -> f_set 100,200,300 each 8 clk, then done; 400 never emitted.
REQ-031 mode 1, f_start 10, f_stop 30, f_step 10, dwell 1 -> f_set 10,20,30,10,20,... with no done; abort during 20 -> en 0, busy 0 next cycle, f_set stays 20.
REQ-032 start with f_step 0, then with f_start 500 > f_stop 400, then with dwell 0 -> err pulse each time, busy never 1.
REQ-033 second start issued in RUN -> ignored, sequence unchanged; rst low during RUN -> all outputs at REQ-027 values immediately, s_clk restarts from div_cnt 0.
REQ-034 f_start = f_stop = 1048575, f_step 1 -> single 21-bit compare ends sweep after one dwell, no wrap to 0.

Source files
------------

// File: rtl/sweep_ctrl.sv
// Frequency sweep controller: steps a frequency word from f_start toward f_stop,
// holding each word for dwell sample periods, and generates the sample clock.
module sweep_ctrl #(
   parameter int unsigned DIV = 50,
   localparam int unsigned FW = 20,
   localparam int unsigned DW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          abort,
   input  logic          mode,
   input  logic [FW-1:0] f_start,
   input  logic [FW-1:0] f_stop,
   input  logic [FW-1:0] f_step,
   input  logic [DW-1:0] dwell,
   output logic          s_clk,
   output logic          en,
   output logic [FW-1:0] f_set,
   output logic          busy,
   output logic          done,
   output logic          err
);

   localparam int unsigned CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned HALF = DIV / 2;

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] div_cnt, div_nxt;
   logic          fall_tick;
   logic [DW-1:0] dwell_cnt, dwell_nxt;
   logic [FW-1:0] f_set_nxt;
   logic          en_nxt, busy_nxt, done_nxt, err_nxt, ld_cfg;
   logic          cfg_bad;
   logic [FW:0]   step_sum;

   logic          cfg_mode;
   logic [FW-1:0] cfg_start, cfg_stop, cfg_step;
   logic [DW-1:0] cfg_dwell;

   // Free-running sample-period divider; s_clk high for the first half.
   assign div_nxt   = (div_cnt == CW'(DIV - 1)) ? '0 : div_cnt + CW'(1);
   assign fall_tick = (div_cnt == CW'(HALF));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_cnt <= '0;
         s_clk   <= 1'b1;
      end else begin
         div_cnt <= div_nxt;
         s_clk   <= (div_nxt < CW'(HALF));
      end
   end

   assign cfg_bad  = (f_step == '0) || (dwell == '0) || (f_start > f_stop);
   // Widened sum so a step past the top of the range cannot wrap to a small word.
   assign step_sum = {1'b0, f_set} + {1'b0, cfg_step};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      f_set_nxt = f_set;
      en_nxt    = en;
      dwell_nxt = dwell_cnt;
      done_nxt  = 1'b0;
      err_nxt   = 1'b0;
      ld_cfg    = 1'b0;
      unique case (state)
         IDLE: begin
            en_nxt = 1'b0;
            if (start) begin
               if (cfg_bad) begin
                  err_nxt = 1'b1;
               end else begin
                  ld_cfg    = 1'b1;
                  state_nxt = LOAD;
               end
            end
         end
         LOAD: begin
            if (fall_tick) begin
               f_set_nxt = cfg_start;
               en_nxt    = 1'b1;
               dwell_nxt = '0;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (fall_tick) begin
               if (dwell_cnt == cfg_dwell - DW'(1)) begin
                  dwell_nxt = '0;
                  if (step_sum <= {1'b0, cfg_stop}) begin
                     f_set_nxt = step_sum[FW-1:0];
                  end else if (cfg_mode) begin
                     f_set_nxt = cfg_start;
                  end else begin
                     en_nxt    = 1'b0;
                     done_nxt  = 1'b1;
                     state_nxt = DONE;
                  end
               end else begin
                  dwell_nxt = dwell_cnt + DW'(1);
               end
            end
         end
         DONE: begin
            en_nxt    = 1'b0;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      // Abort overrides every transition, including a same-cycle start or step.
      if (abort) begin
         state_nxt = IDLE;
         f_set_nxt = f_set;
         en_nxt    = 1'b0;
         dwell_nxt = '0;
         done_nxt  = 1'b0;
         err_nxt   = 1'b0;
         ld_cfg    = 1'b0;
      end
      busy_nxt = (state_nxt == LOAD) || (state_nxt == RUN);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         f_set     <= '0;
         en        <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         dwell_cnt <= '0;
      end else begin
         f_set     <= f_set_nxt;
         en        <= en_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
         err       <= err_nxt;
         dwell_cnt <= dwell_nxt;
      end
   end

   // Sweep configuration, frozen for the whole sweep.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cfg_mode  <= 1'b0;
         cfg_start <= '0;
         cfg_stop  <= '0;
         cfg_step  <= '0;
         cfg_dwell <= '0;
      end else if (ld_cfg) begin
         cfg_mode  <= mode;
         cfg_start <= f_start;
         cfg_stop  <= f_stop;
         cfg_step  <= f_step;
         cfg_dwell <= dwell;
      end
   end

endmodule

// File: tb/tb_sweep_ctrl.sv
// Directed bench for sweep_ctrl with DIV = 8: sweep sequences, hold times,
// step phase, abort, invalid configs, restart-while-busy and reset.
module tb_sweep_ctrl;

   logic        clk, rst, start, abort, mode;
   logic [19:0] f_start, f_stop, f_step;
   logic [15:0] dwell;
   logic        s_clk, en, busy, done, err;
   logic [19:0] f_set;

   int          n_chk = 0;
   int          n_err = 0;
   int          ph;
   logic [19:0] got_q[$];
   logic [19:0] exp_q[$];
   bit          saw_done;

   sweep_ctrl #(.DIV(8)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
      .f_start(f_start), .f_stop(f_stop), .f_step(f_step), .dwell(dwell),
      .s_clk(s_clk), .en(en), .f_set(f_set), .busy(busy), .done(done), .err(err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference divider phase, restarted by reset.
   always @(posedge clk or negedge rst) begin
      if (!rst) ph <= 0;
      else      ph <= (ph == 7) ? 0 : ph + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic do_start(input logic m, input logic [19:0] fs, fp, st, input logic [15:0] dw);
      mode = m; f_start = fs; f_stop = fp; f_step = st; dwell = dw;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Record each new frequency while en is high, checking its phase and hold time.
   task automatic watch(input string tag, input int hold, input int max_cyc, input int stop_after);
      logic [19:0] prev;
      logic        prev_en;
      int          last;
      got_q.delete();
      saw_done = 0;
      prev = f_set; prev_en = en; last = 0;
      for (int c = 1; c <= max_cyc; c++) begin
         @(negedge clk);
         if (en && (!prev_en || f_set != prev)) begin
            chk({tag, "_phase"}, 32'(ph), 32'd5);
            if (got_q.size() > 0) chk({tag, "_hold"}, 32'(c - last), 32'(hold));
            got_q.push_back(f_set);
            last = c;
            if (stop_after > 0 && got_q.size() == stop_after) break;
         end
         if (done) begin
            saw_done = 1;
            chk({tag, "_last_hold"}, 32'(c - last), 32'(hold));
            chk({tag, "_done_en"}, 32'(en), 32'd0);
            chk({tag, "_done_busy"}, 32'(busy), 32'd0);
            break;
         end
         prev = f_set; prev_en = en;
      end
   endtask

   task automatic cmp_seq(input string tag);
      chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         chk($sformatf("%s_val%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; abort = 1'b0; mode = 1'b0;
      f_start = '0; f_stop = '0; f_step = '0; dwell = '0;
      repeat (2) @(negedge clk);
      chk("rst_en", 32'(en), 32'd0);
      chk("rst_fset", 32'(f_set), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_sclk", 32'(s_clk), 32'd1);
      rst = 1'b1;

      // Single sweep, f_stop reachable, dwell 2
      do_start(1'b0, 20'd100, 20'd400, 20'd100, 16'd2);
      chk("t1_busy", 32'(busy), 32'd1);
      watch("t1", 16, 200, 0);
      exp_q = '{20'd100, 20'd200, 20'd300, 20'd400};
      cmp_seq("t1");
      chk("t1_saw_done", 32'(saw_done), 32'd1);
      chk("t1_done_fset", 32'(f_set), 32'd400);
      @(negedge clk);
      chk("t1_done_pulse", 32'(done), 32'd0);
      chk("t1_idle_en", 32'(en), 32'd0);
      chk("t1_idle_fset", 32'(f_set), 32'd400);

      // Single sweep, f_stop not reachable by whole steps
      do_start(1'b0, 20'd100, 20'd350, 20'd100, 16'd1);
      watch("t2", 8, 200, 0);
      exp_q = '{20'd100, 20'd200, 20'd300};
      cmp_seq("t2");
      chk("t2_saw_done", 32'(saw_done), 32'd1);
      chk("t2_done_fset", 32'(f_set), 32'd300);
      @(negedge clk);
      chk("t2_done_pulse", 32'(done), 32'd0);

      // Continuous loop, then abort while 20 is held
      do_start(1'b1, 20'd10, 20'd30, 20'd10, 16'd1);
      watch("t3", 8, 200, 5);
      exp_q = '{20'd10, 20'd20, 20'd30, 20'd10, 20'd20};
      cmp_seq("t3");
      chk("t3_no_done", 32'(saw_done), 32'd0);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("t3_abort_en", 32'(en), 32'd0);
      chk("t3_abort_busy", 32'(busy), 32'd0);
      chk("t3_abort_fset", 32'(f_set), 32'd20);
      chk("t3_abort_done", 32'(done), 32'd0);
      repeat (20) @(negedge clk);
      chk("t3_idle_en", 32'(en), 32'd0);
      chk("t3_idle_busy", 32'(busy), 32'd0);
      chk("t3_idle_fset", 32'(f_set), 32'd20);

      // Invalid configurations
      do_start(1'b0, 20'd100, 20'd400, 20'd0, 16'd2);
      chk("t4a_err", 32'(err), 32'd1);
      chk("t4a_busy", 32'(busy), 32'd0);
      @(negedge clk);
      chk("t4a_err_pulse", 32'(err), 32'd0);
      chk("t4a_busy2", 32'(busy), 32'd0);
      do_start(1'b0, 20'd500, 20'd400, 20'd100, 16'd2);
      chk("t4b_err", 32'(err), 32'd1);
      chk("t4b_busy", 32'(busy), 32'd0);
      @(negedge clk);
      chk("t4b_err_pulse", 32'(err), 32'd0);
      chk("t4b_busy2", 32'(busy), 32'd0);
      do_start(1'b0, 20'd100, 20'd400, 20'd100, 16'd0);
      chk("t4c_err", 32'(err), 32'd1);
      chk("t4c_busy", 32'(busy), 32'd0);
      @(negedge clk);
      chk("t4c_err_pulse", 32'(err), 32'd0);
      chk("t4c_busy2", 32'(busy), 32'd0);
      chk("t4c_fset", 32'(f_set), 32'd20);

      // Start together with abort in IDLE stays idle
      abort = 1'b1;
      do_start(1'b0, 20'd100, 20'd400, 20'd100, 16'd2);
      abort = 1'b0;
      chk("t4d_busy", 32'(busy), 32'd0);
      chk("t4d_err", 32'(err), 32'd0);
      repeat (10) @(negedge clk);
      chk("t4d_en", 32'(en), 32'd0);

      // Second start with new inputs during RUN is ignored
      do_start(1'b0, 20'd100, 20'd400, 20'd100, 16'd2);
      for (int c = 0; c < 20 && !en; c++) @(negedge clk);
      chk("t5_en", 32'(en), 32'd1);
      chk("t5_first", 32'(f_set), 32'd100);
      mode = 1'b1; f_start = 20'd7; f_stop = 20'hFFFFF; f_step = 20'd1; dwell = 16'd1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("t5_busy", 32'(busy), 32'd1);
      watch("t5", 16, 200, 0);
      exp_q = '{20'd200, 20'd300, 20'd400};
      cmp_seq("t5");
      chk("t5_saw_done", 32'(saw_done), 32'd1);
      @(negedge clk);

      // Reset in the middle of RUN
      do_start(1'b0, 20'd100, 20'd400, 20'd100, 16'd2);
      for (int c = 0; c < 20 && !en; c++) @(negedge clk);
      chk("t6_en", 32'(en), 32'd1);
      repeat (3) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("t6_rst_en", 32'(en), 32'd0);
      chk("t6_rst_fset", 32'(f_set), 32'd0);
      chk("t6_rst_busy", 32'(busy), 32'd0);
      chk("t6_rst_done", 32'(done), 32'd0);
      chk("t6_rst_err", 32'(err), 32'd0);
      chk("t6_rst_sclk", 32'(s_clk), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         chk($sformatf("t6_sclk%0d", k), 32'(s_clk), ((k % 8) < 4) ? 32'd1 : 32'd0);
         chk($sformatf("t6_idle%0d", k), 32'({busy, en, done}), 32'd0);
      end

      // Top of range: 21-bit compare must end the sweep, not wrap
      do_start(1'b0, 20'hFFFFF, 20'hFFFFF, 20'd1, 16'd1);
      watch("t7", 8, 200, 0);
      exp_q = '{20'hFFFFF};
      cmp_seq("t7");
      chk("t7_saw_done", 32'(saw_done), 32'd1);
      @(negedge clk);
      chk("t7_fset", 32'(f_set), 32'hFFFFF);
      chk("t7_en", 32'(en), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
